// File: rtl/pipe_pkg.sv
// Shared widths and occupancy encoding for the two-entry pipeline stage register.
// The stage holds an OUT entry and a SKID entry and moves between EMPTY, ONE and FULL.
package pipe_pkg;

  localparam int WB_W_DEF   = 2;
  localparam int M_W_DEF    = 2;
  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 5;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones, never wraps.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage carrying WB/M controls, ALU result, store data
// and destination register; every output, including in_ready, comes straight from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WB_W   = WB_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [RA_W-1:0]   write_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] store_data,
  output logic [RA_W-1:0]   write_reg,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves whenever valid and ready are both high at a rising edge;
  // valid never waits on ready, and in_ready never looks at out_ready combinationally.

  state_t              state;
  logic [WB_W-1:0]     skid_wb;
  logic [M_W-1:0]      skid_m;
  logic [DATA_W-1:0]   skid_alu;
  logic [DATA_W-1:0]   skid_store;
  logic [RA_W-1:0]     skid_reg;

  logic                xfer_in;
  logic                xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      wb_out     <= '0;
      m_out      <= '0;
      alu_out    <= '0;
      store_data <= '0;
      write_reg  <= '0;
      skid_wb    <= '0;
      skid_m     <= '0;
      skid_alu   <= '0;
      skid_store <= '0;
      skid_reg   <= '0;
    end else if (flush) begin
      // Data fields keep their last value; only the controls are forced to a bubble.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      wb_out    <= '0;
      m_out     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            state      <= ST_ONE;
            out_valid  <= 1'b1;
            wb_out     <= wb_in;
            m_out      <= m_in;
            alu_out    <= alu_out_in;
            store_data <= store_data_in;
            write_reg  <= write_reg_in;
          end
        end
        ST_ONE: begin
          if (xfer_in && xfer_out) begin
            wb_out     <= wb_in;
            m_out      <= m_in;
            alu_out    <= alu_out_in;
            store_data <= store_data_in;
            write_reg  <= write_reg_in;
          end else if (xfer_in) begin
            state      <= ST_FULL;
            in_ready   <= 1'b0;
            skid_wb    <= wb_in;
            skid_m     <= m_in;
            skid_alu   <= alu_out_in;
            skid_store <= store_data_in;
            skid_reg   <= write_reg_in;
          end else if (xfer_out) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            wb_out    <= '0;
            m_out     <= '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so the only possible move is draining OUT.
          if (xfer_out) begin
            state      <= ST_ONE;
            in_ready   <= 1'b1;
            wb_out     <= skid_wb;
            m_out      <= skid_m;
            alu_out    <= skid_alu;
            store_data <= skid_store;
            write_reg  <= skid_reg;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          wb_out    <= '0;
          m_out     <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (stall counter narrowed to 4 bits to reach saturation).
module tb_pipe_stage_reg;

  localparam int WB_W = 2, M_W = 2, DATA_W = 32, RA_W = 5, CNT_W = 4;

  logic              clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WB_W-1:0]   wb_in, wb_out;
  logic [M_W-1:0]    m_in, m_out;
  logic [DATA_W-1:0] alu_out_in, store_data_in, alu_out, store_data;
  logic [RA_W-1:0]   write_reg_in, write_reg;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_reg #(
    .WB_W(WB_W), .M_W(M_W), .DATA_W(DATA_W), .RA_W(RA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .m_in(m_in), .alu_out_in(alu_out_in),
    .store_data_in(store_data_in), .write_reg_in(write_reg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .m_out(m_out), .alu_out(alu_out),
    .store_data(store_data), .write_reg(write_reg),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_in = '0; m_in = '0; alu_out_in = '0; store_data_in = '0; write_reg_in = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [DATA_W-1:0] alu, input logic [WB_W-1:0] wb,
                       input logic [M_W-1:0] m, input logic [RA_W-1:0] ra);
    in_valid = 1'b1; alu_out_in = alu; store_data_in = ~alu;
    wb_in = wb; m_in = m; write_reg_in = ra;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (wb_out !== '0 || m_out !== '0) begin bad++; $display("FAIL reset_ctrl wb=%0h m=%0h exp=0", wb_out, m_out); end
    total++; if (alu_out !== '0 || store_data !== '0 || write_reg !== '0) begin
      bad++; $display("FAIL reset_data alu=%0h sd=%0h wr=%0h exp=0", alu_out, store_data, write_reg); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    drive(32'h0000_00AA, 2'd3, 2'd2, 5'd5);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0b exp=1", out_valid); end
    total++; if (alu_out !== 32'hAA) begin bad++; $display("FAIL lat_alu got=%0h exp=aa", alu_out); end
    total++; if (write_reg !== 5'd5) begin bad++; $display("FAIL lat_wr got=%0d exp=5", write_reg); end
    total++; if (wb_out !== 2'd3 || m_out !== 2'd2) begin bad++; $display("FAIL lat_ctrl wb=%0d m=%0d exp=3/2", wb_out, m_out); end
    total++; if (store_data !== 32'hFFFF_FF55) begin bad++; $display("FAIL lat_sd got=%0h exp=ffffff55", store_data); end
    step();
    total++; if (out_valid !== 1'b0 || wb_out !== '0 || m_out !== '0) begin
      bad++; $display("FAIL lat_bubble v=%0b wb=%0d m=%0d exp=0/0/0", out_valid, wb_out, m_out); end
  endtask

  task automatic test_skid_order();
    do_reset();
    out_ready = 1'b0;
    drive(32'h11, 2'd1, 2'd1, 5'd1);
    step();
    total++; if (out_valid !== 1'b1 || alu_out !== 32'h11 || in_ready !== 1'b1) begin
      bad++; $display("FAIL skid_first v=%0b alu=%0h rdy=%0b exp=1/11/1", out_valid, alu_out, in_ready); end
    drive(32'h22, 2'd2, 2'd2, 5'd2);
    step();
    total++; if (in_ready !== 1'b0 || alu_out !== 32'h11) begin
      bad++; $display("FAIL skid_full rdy=%0b alu=%0h exp=0/11", in_ready, alu_out); end
    drive(32'h33, 2'd3, 2'd3, 5'd3);
    step(); step();
    total++; if (in_ready !== 1'b0 || alu_out !== 32'h11 || stall_cnt !== 4'd3) begin
      bad++; $display("FAIL skid_held rdy=%0b alu=%0h stall=%0d exp=0/11/3", in_ready, alu_out, stall_cnt); end
    out_ready = 1'b1;
    step();
    total++; if (alu_out !== 32'h22 || wb_out !== 2'd2 || write_reg !== 5'd2 || in_ready !== 1'b1) begin
      bad++; $display("FAIL skid_second alu=%0h wb=%0d wr=%0d rdy=%0b exp=22/2/2/1", alu_out, wb_out, write_reg, in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'h33 || write_reg !== 5'd3) begin
      bad++; $display("FAIL skid_third v=%0b alu=%0h wr=%0d exp=1/33/3", out_valid, alu_out, write_reg); end
    step();
    total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
      bad++; $display("FAIL skid_drain v=%0b stall=%0d exp=0/3", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(32'h44, 2'd1, 2'd1, 5'd4); step();
    drive(32'h55, 2'd2, 2'd2, 5'd5); step();
    flush = 1'b1;
    drive(32'h66, 2'd3, 2'd3, 5'd6);
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || wb_out !== '0 || m_out !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state v=%0b wb=%0d m=%0d rdy=%0b exp=0/0/0/1", out_valid, wb_out, m_out, in_ready); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL flush_stall got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cyc=%0d v=%0b alu=%0h exp=0", i, out_valid, alu_out); end
    end
    drive(32'h77, 2'd1, 2'd0, 5'd7);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_out !== 32'h77) begin
      bad++; $display("FAIL flush_next v=%0b alu=%0h exp=1/77", out_valid, alu_out); end
    step();
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    out_ready = 1'b0;
    drive(32'h99, 2'd1, 2'd1, 5'd9);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_cnt = (k > 15) ? 4'd15 : 4'(k);
      total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt); end
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_v;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) exp_q.push_back(DATA_W'(i));
    for (int i = 1; i <= 8; i++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, in_ready); end
      drive(DATA_W'(i), 2'd1, 2'd1, RA_W'(i));
      step();
      exp_v = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || alu_out !== exp_v) begin
        bad++; $display("FAIL b2b_out i=%0d v=%0b alu=%0h exp=1/%0h", i, out_valid, alu_out, exp_v); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || stall_cnt !== '0) begin
      bad++; $display("FAIL b2b_end v=%0b stall=%0d exp=0/0", out_valid, stall_cnt); end
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0;
    drive(32'hAB, 2'd3, 2'd3, 5'd10); step();
    drive(32'hCD, 2'd3, 2'd3, 5'd11); step(); step();
    rst = 1'b1; flush = 1'b1;
    drive(32'hEF, 2'd3, 2'd3, 5'd12);
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
      bad++; $display("FAIL rstfull_ctl v=%0b rdy=%0b stall=%0d exp=0/1/0", out_valid, in_ready, stall_cnt); end
    total++; if (wb_out !== '0 || m_out !== '0 || alu_out !== '0 || store_data !== '0 || write_reg !== '0) begin
      bad++; $display("FAIL rstfull_data wb=%0d m=%0d alu=%0h sd=%0h wr=%0d exp=0", wb_out, m_out, alu_out, store_data, write_reg); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_ghost v=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skid_order();
    test_flush();
    test_saturate();
    test_back_to_back();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WB_W, default 2, write-back control field width.
REQ-002 The block SHALL have parameter M_W, default 2, memory-stage control field width.
REQ-003 The block SHALL have parameter DATA_W, default 32, ALU result and store-data width.
REQ-004 The block SHALL have parameter RA_W, default 5, destination register index width.
REQ-005 The block SHALL have parameter CNT_W, default 16, stall counter width.
REQ-006 The block SHALL have one clock and a synchronous active-high reset. Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept
- wb_in  in  WB_W  write-back controls
- m_in  in  M_W  memory controls
- alu_out_in  in  DATA_W  ALU result
- store_data_in  in  DATA_W  data-memory write data
- write_reg_in  in  RA_W  destination register
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts
- wb_out  out  WB_W  held write-back controls
- m_out  out  M_W  held memory controls
- alu_out  out  DATA_W  held ALU result
- store_data  out  DATA_W  held store data
- write_reg  out  RA_W  held destination register
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Function
REQ-007 The block SHALL hold two entries, OUT (drives outputs) and SKID, each with a valid bit; states EMPTY (none), ONE (OUT only), FULL (both).
REQ-008 in_ready SHALL be a register output equal to NOT SKID.valid, never depending combinationally on out_ready.
REQ-009 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-010 EMPTY + transfer in -> ONE; payload appears on outputs the next cycle (latency 1).
REQ-011 ONE + transfer in + transfer out -> ONE with OUT replaced by new payload.
REQ-012 ONE + transfer in, no transfer out -> FULL; payload stored in SKID.
REQ-013 ONE + transfer out, no transfer in -> EMPTY.
REQ-014 FULL + transfer out -> ONE; SKID moves to OUT; no transfer in possible while FULL.
REQ-015 Payload order SHALL be preserved; no payload dropped or duplicated except by flush.
REQ-016 flush SHALL take priority: next state EMPTY, any payload presented that cycle discarded, in_ready 1 next cycle.
REQ-017 While out_valid is 0, wb_out and m_out SHALL be all-zero (bubble); data outputs unspecified-but-stable.
REQ-018 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturate at all-ones, never wrap; flush does not clear it.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 On rst: state EMPTY, out_valid 0, in_ready 1, wb_out/m_out/alu_out/store_data/write_reg 0, stall_cnt 0; rst overrides flush and all transfers, including mid-FULL.

Structure
REQ-021 Widths defaults and the state encoding (EMPTY/ONE/FULL) SHALL live in shared package pipe_pkg.
REQ-022 The stall counter SHALL be sub-module sat_counter (parameter CNT_W, inputs clk, rst, inc; output count).

Verification
REQ-023 Reset, then in_valid=1, alu_out_in=0x0000_00AA, write_reg_in=5, out_ready=1 -> next cycle out_valid=1, alu_out=0xAA, write_reg=5.
REQ-024 out_ready=0, push A=0x11 then B=0x22 -> FULL, in_ready=0; third push held; release out_ready -> outputs 0x11, 0x22, then third in order.
REQ-025 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, wb_out=0, m_out=0, in_ready=1; flushed payloads never appear.
REQ-026 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-027 Continuous in_valid=1, out_ready=1 for 8 cycles with values 1..8 -> one output per cycle, 1..8, in_ready never 0.
REQ-028 rst asserted while FULL with flush=1 -> next cycle all outputs 0, stall_cnt 0, in_ready 1.
